ysyx_22050058_ifu: RTL and testbench

YSYX_22050058_IFU -- requirements
Module: ysyx_22050058_ifu

---
 rtl/ysyx_22050058_ifu_if.sv | 24 ++
 rtl/ysyx_22050058_ifu.sv | 77 +++++++
 tb/tb_ysyx_22050058_ifu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22050058_ifu_if.sv
// Fetch-unit bus: instruction ROM port, decode handshake and control inputs.
// master = fetch unit, slave = surrounding core/ROM.
interface ysyx_22050058_ifu_if;
  logic        rom_ce_o;
  logic [63:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [63:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        halt_i;
  logic        halted_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, halted_o,
    input  rom_inst_i, id_ready_i, redirect_i, redirect_pc_i, halt_i
  );
  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, halted_o,
    output rom_inst_i, id_ready_i, redirect_i, redirect_pc_i, halt_i
  );
endinterface

// File: rtl/ysyx_22050058_ifu.sv
// Instruction fetch unit: PC register, combinational ROM fetch, 2-entry fetch
// buffer toward decode, redirect flush and halt/drain handling.
module ysyx_22050058_ifu #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22050058_ifu_if.master      bus
);
  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

  state_t      state, state_nx;
  logic [63:0] pc;
  logic [1:0]  count;
  logic        wr_ptr, rd_ptr;
  logic [63:0] buf_pc   [FIFO_DEPTH];
  logic [31:0] buf_inst [FIFO_DEPTH];
  logic        ce, redir, valid, push, pop;

  assign ce    = (state == FETCH) && (count < 2'(FIFO_DEPTH));
  // Redirects are dead once halted; the PC must stay frozen.
  assign redir = bus.redirect_i && (state != HALT);
  assign valid = (count != 2'd0);
  assign push  = ce && !redir;
  assign pop   = valid && bus.id_ready_i && !redir;

  assign bus.rom_ce_o   = ce;
  assign bus.rom_addr_o = pc;
  assign bus.id_valid_o = valid;
  assign bus.id_pc_o    = valid ? buf_pc[rd_ptr]   : 64'd0;
  assign bus.id_inst_o  = valid ? buf_inst[rd_ptr] : 32'd0;
  assign bus.halted_o   = (state == HALT) && !valid;

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = bus.halt_i ? HALT : FETCH;
      FETCH:   if (bus.halt_i) state_nx = HALT;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (redir) begin
      pc     <= {bus.redirect_pc_i[63:2], 2'b00};
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        pc     <= pc + 64'd4;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: head outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= pc;
      buf_inst[wr_ptr] <= bus.rom_inst_i;
    end
  end
endmodule

// File: tb/tb_ysyx_22050058_ifu.sv
// Randomized bench for the fetch unit against a queue-based behavioural model.
module tb_ysyx_22050058_ifu;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] rom_key = 32'd0;

  ysyx_22050058_ifu_if bus ();
  ysyx_22050058_ifu #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  assign bus.rom_inst_i = bus.rom_addr_o[31:0] ^ rom_key;

  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  int          m_mode;   // 0 boot, 1 fetching, 2 stopped
  logic [63:0] m_pc;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic fetching;
    fetching = (m_mode == 1) && (q.size() < 2);
    chk("rom_ce",   64'(bus.rom_ce_o),   64'(fetching));
    chk("rom_addr", bus.rom_addr_o,      m_pc);
    chk("id_valid", 64'(bus.id_valid_o), 64'(q.size() != 0));
    chk("id_pc",    bus.id_pc_o,         q.size() != 0 ? q[0].pc : 64'd0);
    chk("id_inst",  64'(bus.id_inst_o),  q.size() != 0 ? 64'(q[0].inst) : 64'd0);
    chk("halted",   64'(bus.halted_o),   64'((m_mode == 2) && (q.size() == 0)));
  endtask

  task automatic model_edge(input bit rdy, input bit rd, input logic [63:0] rpc, input bit hl);
    bit fetching;
    fetching = (m_mode == 1) && (q.size() < 2);
    if (rd && m_mode != 2) begin
      q.delete();
      m_pc = rpc & ~64'd3;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (fetching) begin
        q.push_back('{pc: m_pc, inst: m_pc[31:0] ^ rom_key});
        m_pc = m_pc + 64'd4;
      end
    end
    if (m_mode == 0)      m_mode = hl ? 2 : 1;
    else if (m_mode == 1) m_mode = hl ? 2 : 1;
  endtask

  task automatic step(input bit rdy, input bit rd, input logic [63:0] rpc, input bit hl);
    @(negedge clk);
    bus.id_ready_i    = rdy;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.halt_i        = hl;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge(rdy, rd, rpc, hl);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear before any edge.
  task automatic do_reset(input logic [31:0] key);
    @(negedge clk);
    #2;
    rst = 1'b0;
    bus.id_ready_i = 1'b0; bus.redirect_i = 1'b0; bus.halt_i = 1'b0;
    bus.redirect_pc_i = 64'd0;
    #1;
    chk("rst_ce",     64'(bus.rom_ce_o),   64'd0);
    chk("rst_valid",  64'(bus.id_valid_o), 64'd0);
    chk("rst_pc",     bus.id_pc_o,         64'd0);
    chk("rst_inst",   64'(bus.id_inst_o),  64'd0);
    chk("rst_halted", 64'(bus.halted_o),   64'd0);
    chk("rst_addr",   bus.rom_addr_o,      RST_PC);
    rom_key = key;
    q.delete();
    m_mode = 0;
    m_pc   = RST_PC;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    bus.id_ready_i = 1'b0; bus.redirect_i = 1'b0; bus.halt_i = 1'b0;
    bus.redirect_pc_i = 64'd0;
    q.delete(); m_mode = 0; m_pc = RST_PC;

    // Stream with decode always ready and ROM word = address.
    do_reset(32'd0);
    repeat (6) step(1, 0, 64'd0, 0);
    // Backpressure fills the buffer, then drains in order.
    repeat (5) step(0, 0, 64'd0, 0);
    repeat (4) step(1, 0, 64'd0, 0);
    // Redirect with a full buffer, misaligned target.
    repeat (3) step(0, 0, 64'd0, 0);
    step(0, 1, 64'h0000_0000_8000_1003, 0);
    repeat (3) step(1, 0, 64'd0, 0);
    // PC wrap-around.
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    repeat (4) step(1, 0, 64'd0, 0);
    // Halt with one entry buffered; a later redirect must be ignored.
    step(1, 0, 64'd0, 1);
    repeat (3) step(1, 0, 64'd0, 0);
    step(1, 1, 64'h0000_0000_0000_1234, 0);
    repeat (2) step(1, 0, 64'd0, 0);
    // Halt and redirect on the same edge, then drain.
    do_reset(32'h5A5A_0F0F);
    repeat (3) step(0, 0, 64'd0, 0);
    step(0, 1, 64'h0000_0000_0000_2002, 1);
    repeat (3) step(1, 0, 64'd0, 0);
    // Halt and redirect during the boot cycle.
    do_reset(32'h1234_5678);
    step(1, 1, 64'h0000_0000_0000_4000, 1);
    repeat (3) step(1, 0, 64'd0, 0);
    // Reset mid-operation with a full buffer.
    do_reset(32'hDEAD_BEEF);
    repeat (4) step(0, 0, 64'd0, 0);
    do_reset(32'h0BAD_F00D);
    repeat (4) step(1, 0, 64'd0, 0);

    for (int r = 0; r < 20; r++) begin
      do_reset($urandom);
      for (int c = 0; c < 150; c++) begin
        logic [63:0] tgt;
        tgt = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 8, tgt,
             $urandom_range(0, 199) < 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
